// File: rtl/regfile_rename_if.sv
// Bundle of decode/issue/commit signals for the renaming register file.
// master = the core side driving requests, slave = the register file.
interface regfile_rename_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int TW   = 4,
  parameter int NRD  = 2
);
  logic                 flush;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;
  logic [TW-1:0]        iss_tag;
  logic                 cmt_en;
  logic [AW-1:0]        cmt_addr;
  logic [TW-1:0]        cmt_tag;
  logic [XLEN-1:0]      cmt_data;
  logic [NRD-1:0]       rd_req;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NRD*TW-1:0]    rd_tag;

  modport master (
    output flush, iss_en, iss_addr, iss_tag,
    output cmt_en, cmt_addr, cmt_tag, cmt_data,
    output rd_req, rd_addr,
    input  rd_data, rd_busy, rd_tag
  );

  modport slave (
    input  flush, iss_en, iss_addr, iss_tag,
    input  cmt_en, cmt_addr, cmt_tag, cmt_data,
    input  rd_req, rd_addr,
    output rd_data, rd_busy, rd_tag
  );
endinterface

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename status (busy + ROB tag).
// Reads are combinational with a commit bypass; issue renames rd; commit writes
// data and retires the tag if it is still the newest producer; flush clears busy.
module regfile_rename #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int TW   = 4,
  parameter int NRD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  regfile_rename_if.slave   bus
);

  logic [XLEN-1:0] data_q [NREG];
  logic [XLEN-1:0] data_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [TW-1:0]   tag_q  [NREG];
  logic [TW-1:0]   tag_d  [NREG];

  logic cmt_hit;
  logic iss_hit;

  assign cmt_hit = bus.cmt_en && (bus.cmt_addr != '0);
  // Flush suppresses renaming entirely, so the instruction never becomes a producer.
  assign iss_hit = bus.iss_en && (bus.iss_addr != '0) && !bus.flush;

  // Next-state: commit data write, then busy clear, then issue/flush overrides on top.
  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (cmt_hit) begin
      data_d[bus.cmt_addr] = bus.cmt_data;
      // Only the newest producer may retire the busy bit; an older tag leaves it set.
      if (busy_q[bus.cmt_addr] && (tag_q[bus.cmt_addr] == bus.cmt_tag)) begin
        busy_d[bus.cmt_addr] = 1'b0;
      end
    end
    if (bus.flush) begin
      busy_d = '0;
    end else if (iss_hit) begin
      busy_d[bus.iss_addr] = 1'b1;
      tag_d[bus.iss_addr]  = bus.iss_tag;
    end
  end

  // State registers with synchronous reset clearing everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '{default: '0};
      busy_q <= '0;
      tag_q  <= '{default: '0};
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  // Independent combinational read ports; they see pre-edge state plus commit bypass.
  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data_o;
      logic            busy_o;
      logic [TW-1:0]   tag_o;

      assign addr = bus.rd_addr[gi*AW +: AW];

      // Zero for reset/idle/x0, bypass a committing newest producer, else stored state.
      always_comb begin
        data_o = '0;
        busy_o = 1'b0;
        tag_o  = '0;
        if (!rst && bus.rd_req[gi] && (addr != '0)) begin
          if (bus.cmt_en && (bus.cmt_addr == addr) && busy_q[addr] &&
              (tag_q[addr] == bus.cmt_tag)) begin
            data_o = bus.cmt_data;
          end else begin
            data_o = data_q[addr];
            busy_o = busy_q[addr];
            tag_o  = tag_q[addr];
          end
        end
      end

      assign bus.rd_data[gi*XLEN +: XLEN] = data_o;
      assign bus.rd_busy[gi]              = busy_o;
      assign bus.rd_tag[gi*TW +: TW]      = tag_o;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_rename.sv
// Directed bench for regfile_rename: the driver pushes hand-computed expected
// read responses into a queue, the monitor pops and compares on each requested port.
module tb_regfile_rename;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int TW   = 4;
  localparam int NRD  = 2;

  typedef struct {
    logic [XLEN-1:0] data;
    logic            busy;
    logic [TW-1:0]   tag;
    logic            chk_tag;
    string           name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  regfile_rename_if #(.XLEN(XLEN), .AW(AW), .TW(TW), .NRD(NRD)) bus ();

  regfile_rename #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .TW(TW), .NRD(NRD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic clear_inputs();
    bus.flush    = 1'b0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
    bus.iss_tag  = '0;
    bus.cmt_en   = 1'b0;
    bus.cmt_addr = '0;
    bus.cmt_tag  = '0;
    bus.cmt_data = '0;
    bus.rd_req   = '0;
    bus.rd_addr  = '0;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [TW-1:0] t);
    bus.iss_en   = 1'b1;
    bus.iss_addr = a;
    bus.iss_tag  = t;
  endtask

  task automatic commit(input logic [AW-1:0] a, input logic [TW-1:0] t,
                        input logic [XLEN-1:0] d);
    bus.cmt_en   = 1'b1;
    bus.cmt_addr = a;
    bus.cmt_tag  = t;
    bus.cmt_data = d;
  endtask

  // Request a read on port p and queue its expected response.
  task automatic rd(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                    input logic b, input logic [TW-1:0] t, input logic ct, input string nm);
    exp_t e;
    bus.rd_req[p]          = 1'b1;
    bus.rd_addr[p*AW +: AW] = a;
    e.data = d; e.busy = b; e.tag = t; e.chk_tag = ct; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Let the monitor sample, apply the edge, then return inputs to idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    clear_inputs();
    rst = 1'b0;
  endtask

  // Monitor: requested ports are checked against the queue, idle ports must read zero.
  always @(negedge clk) begin
    logic [XLEN-1:0] ad;
    logic            ab;
    logic [TW-1:0]   at;
    exp_t            e;
    for (int i = 0; i < NRD; i++) begin
      ad = bus.rd_data[i*XLEN +: XLEN];
      ab = bus.rd_busy[i];
      at = bus.rd_tag[i*TW +: TW];
      if (bus.rd_req[i]) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL no_expect port%0d: got data=%h busy=%b tag=%h, required nothing queued",
                   i, ad, ab, at);
        end else begin
          e = exp_q.pop_front();
          if (ad !== e.data || ab !== e.busy || (e.chk_tag && at !== e.tag)) begin
            n_bad++;
            $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, required data=%h busy=%b tag=%h",
                     e.name, i, ad, ab, at, e.data, e.busy, e.tag);
          end else begin
            $display("ok   %s port%0d: data=%h busy=%b tag=%h", e.name, i, ad, ab, at);
          end
        end
      end else begin
        n_cmp++;
        if (ad !== '0 || ab !== 1'b0 || at !== '0) begin
          n_bad++;
          $display("FAIL idle_port%0d: got data=%h busy=%b tag=%h, required all zero",
                   i, ad, ab, at);
        end
      end
    end
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset held two cycles
    rst = 1'b1; rd(0, 5'd1, 32'h0, 1'b0, 4'h0, 1'b1, "rst_hold_rd"); cyc();
    rst = 1'b1; cyc();

    // 1. every register reads zero on both ports
    for (int a = 1; a < NREG; a++) begin
      rd(0, AW'(a), 32'h0, 1'b0, 4'h0, 1'b1, "reset_state");
      rd(1, AW'(a), 32'h0, 1'b0, 4'h0, 1'b1, "reset_state");
      cyc();
    end

    // 2. issue / read busy / commit bypass / read after commit
    issue(5'd5, 4'd3); rd(0, 5'd5, 32'h0, 1'b0, 4'h0, 1'b1, "own_issue_invisible"); cyc();
    rd(0, 5'd5, 32'h0, 1'b1, 4'd3, 1'b1, "x5_busy"); cyc();
    commit(5'd5, 4'd3, 32'hDEADBEEF);
    rd(0, 5'd5, 32'hDEADBEEF, 1'b0, 4'h0, 1'b1, "x5_bypass");
    rd(1, 5'd5, 32'hDEADBEEF, 1'b0, 4'h0, 1'b1, "x5_bypass"); cyc();
    rd(0, 5'd5, 32'hDEADBEEF, 1'b0, 4'h0, 1'b0, "x5_committed"); cyc();

    // 3. stale commit keeps newer producer
    issue(5'd7, 4'd1); cyc();
    issue(5'd7, 4'd2); cyc();
    commit(5'd7, 4'd1, 32'h11); rd(0, 5'd7, 32'h0, 1'b1, 4'd2, 1'b1, "x7_stale_cmt_rd"); cyc();
    rd(0, 5'd7, 32'h11, 1'b1, 4'd2, 1'b1, "x7_after_stale"); cyc();

    // 4. same-cycle issue and commit on x9
    issue(5'd9, 4'd4); cyc();
    issue(5'd9, 4'd6); commit(5'd9, 4'd4, 32'h55);
    rd(0, 5'd9, 32'h55, 1'b0, 4'h0, 1'b1, "x9_bypass"); cyc();
    rd(0, 5'd9, 32'h55, 1'b1, 4'd6, 1'b1, "x9_reissued"); cyc();

    // 5. flush recovery
    issue(5'd3, 4'd1); cyc();
    issue(5'd4, 4'd2); cyc();
    issue(5'd8, 4'd5); cyc();
    bus.flush = 1'b1; issue(5'd10, 4'd7); commit(5'd3, 4'd1, 32'h77);
    rd(0, 5'd4, 32'h0, 1'b1, 4'd2, 1'b1, "flush_cycle_x4");
    rd(1, 5'd3, 32'h77, 1'b0, 4'h0, 1'b1, "flush_cycle_x3"); cyc();
    rd(0, 5'd3, 32'h77, 1'b0, 4'h0, 1'b0, "post_flush_x3");
    rd(1, 5'd4, 32'h0, 1'b0, 4'h0, 1'b0, "post_flush_x4"); cyc();
    rd(0, 5'd8, 32'h0, 1'b0, 4'h0, 1'b0, "post_flush_x8");
    rd(1, 5'd10, 32'h0, 1'b0, 4'h0, 1'b1, "post_flush_x10"); cyc();

    // 6. x0 is hardwired
    issue(5'd0, 4'd5); commit(5'd0, 4'd5, 32'h99);
    rd(0, 5'd0, 32'h0, 1'b0, 4'h0, 1'b1, "x0_same_cycle");
    rd(1, 5'd0, 32'h0, 1'b0, 4'h0, 1'b1, "x0_same_cycle"); cyc();
    rd(0, 5'd0, 32'h0, 1'b0, 4'h0, 1'b1, "x0_after"); cyc();

    // 6. reset mid-sequence with issue and commit active
    issue(5'd12, 4'd3); commit(5'd11, 4'd0, 32'hAB); cyc();
    rd(0, 5'd11, 32'hAB, 1'b0, 4'h0, 1'b0, "x11_written");
    rd(1, 5'd12, 32'h0, 1'b1, 4'd3, 1'b1, "x12_busy"); cyc();
    rst = 1'b1; issue(5'd13, 4'd2); commit(5'd11, 4'd0, 32'hCD);
    rd(0, 5'd11, 32'h0, 1'b0, 4'h0, 1'b1, "rst_gates_x11");
    rd(1, 5'd12, 32'h0, 1'b0, 4'h0, 1'b1, "rst_gates_x12"); cyc();
    rd(0, 5'd11, 32'h0, 1'b0, 4'h0, 1'b1, "post_rst_x11");
    rd(1, 5'd12, 32'h0, 1'b0, 4'h0, 1'b1, "post_rst_x12"); cyc();
    rd(0, 5'd13, 32'h0, 1'b0, 4'h0, 1'b1, "post_rst_x13");
    rd(1, 5'd7, 32'h0, 1'b0, 4'h0, 1'b1, "post_rst_x7"); cyc();

    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
